// File: rtl/vga_scan_controller.sv
// vga_scan_controller
//   Raster-scan timing generator and 1 bpp pixel consumer. Stage 0 holds the
//   tick divider and the h/v scan counters and drives the memory address
//   combinationally. Stage 1 registers sync, blanking, colour and frame_start
//   one pixel tick later, so all display-side outputs stay mutually aligned.
//   Optional build macro: VGA_BORDER_EN draws a 1-pixel FG_COLOUR frame
//   around the visible area, whatever the pixel bit is.
module vga_scan_controller #(
   parameter int          CLK_DIV   = 2,
   parameter int          H_ACTIVE  = 640,
   parameter int          H_FP      = 16,
   parameter int          H_SYNC    = 96,
   parameter int          H_BP      = 48,
   parameter int          V_ACTIVE  = 480,
   parameter int          V_FP      = 10,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 33,
   parameter logic [11:0] FG_COLOUR = 12'hFFF,
   parameter logic [11:0] BG_COLOUR = 12'h000
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        enable,
   input  logic        pixel,
   output logic [9:0]  pixel_x,
   output logic [8:0]  pixel_y,
   output logic        hsync_n,
   output logic        vsync_n,
   output logic        video_on,
   output logic [11:0] rgb,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // A one-bit divider still works for CLK_DIV=1: it never leaves 0.
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   // Stage 0: divider and scan counters
   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       h_q, h_d;
   logic [9:0]       v_q, v_d;
   logic             tick;
   logic             active0;

   // Stage 1: registered display outputs
   logic             hsync_n_q, hsync_n_d;
   logic             vsync_n_q, vsync_n_d;
   logic             video_on_q;
   logic [11:0]      rgb_q, rgb_d;
   logic             frame_start_q, frame_start_d;
   logic             paint_fg;

   assign tick    = (div_q == DIV_LAST);
   assign active0 = (h_q < H_ACT) && (v_q < V_ACT);

   // Memory address: follows the scan in the visible area, parked at 0 in blanking
   always_comb begin
      pixel_x = 10'd0;
      pixel_y = 9'd0;
      if (active0) begin
         pixel_x = h_q;
         pixel_y = v_q[8:0];
      end
   end

   // Next counter values: divider wraps on tick, h advances on tick, v on line end
   always_comb begin
      div_d = div_q + DIV_ONE;
      h_d   = h_q;
      v_d   = v_q;
      if (tick) begin
         div_d = '0;
         if (h_q == H_LAST) begin
            h_d = 10'd0;
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
      if (!enable) begin
         div_d = '0;
         h_d   = 10'd0;
         v_d   = 10'd0;
      end
   end

   // Decide whether the sampled position is painted in the foreground colour
`ifdef VGA_BORDER_EN
   always_comb begin
      paint_fg = pixel || (h_q == 10'd0) || (h_q == H_ACT - 10'd1) ||
                 (v_q == 10'd0) || (v_q == V_ACT - 10'd1);
   end
`else
   always_comb begin
      paint_fg = pixel;
   end
`endif

   // Next stage-1 values derived from the stage-0 position being sampled
   always_comb begin
      hsync_n_d     = !((h_q >= HS_START) && (h_q < HS_END));
      vsync_n_d     = !((v_q >= VS_START) && (v_q < VS_END));
      rgb_d         = active0 ? (paint_fg ? FG_COLOUR : BG_COLOUR) : 12'h000;
      frame_start_d = enable && tick && (h_q == 10'd0) && (v_q == 10'd0);
   end

   // All state: async reset, synchronous clear on enable low, stage 1 loads on tick
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         div_q         <= '0;
         h_q           <= 10'd0;
         v_q           <= 10'd0;
         hsync_n_q     <= 1'b1;
         vsync_n_q     <= 1'b1;
         video_on_q    <= 1'b0;
         rgb_q         <= 12'h000;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         h_q           <= h_d;
         v_q           <= v_d;
         frame_start_q <= frame_start_d;
         if (!enable) begin
            hsync_n_q  <= 1'b1;
            vsync_n_q  <= 1'b1;
            video_on_q <= 1'b0;
            rgb_q      <= 12'h000;
         end else if (tick) begin
            hsync_n_q  <= hsync_n_d;
            vsync_n_q  <= vsync_n_d;
            video_on_q <= active0;
            rgb_q      <= rgb_d;
         end
      end
   end

   assign hsync_n     = hsync_n_q;
   assign vsync_n     = vsync_n_q;
   assign video_on    = video_on_q;
   assign rgb         = rgb_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// tb_vga_scan_controller
//   Scoreboard bench on a shrunk raster (24 ticks x 13 lines, CLK_DIV=2) so
//   several frames fit in a short run. Every cycle the driver pushes the
//   expected output word for the edge just taken; a negedge monitor pops and
//   compares. The monitor also checks hsync/vsync low widths in HCLK cycles.
//   Build with VGA_BORDER_EN defined to exercise the border frame.
module tb_vga_scan_controller;

   localparam int CD = 2;
   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;   // 24
   localparam int VT = VA + VF + VS + VB;   // 13
   localparam logic [11:0] FG = 12'hFFF;
   localparam int HS_LOW_CYC = 6;           // 3 ticks x 2 HCLK
   localparam int VS_LOW_CYC = 96;          // 2 lines x 24 ticks x 2 HCLK

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        enable;
   logic        pixel;
   logic [9:0]  pixel_x;
   logic [8:0]  pixel_y;
   logic        hsync_n, vsync_n, video_on;
   logic [11:0] rgb;
   logic        frame_start;

   logic        pix_force;
   int          k;
   int          tests_run = 0;
   int          failed    = 0;
   logic [34:0] exp_q[$];

   vga_scan_controller #(
      .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .FG_COLOUR(12'hFFF), .BG_COLOUR(12'h000)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .enable(enable), .pixel(pixel),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync_n(hsync_n),
      .vsync_n(vsync_n), .video_on(video_on), .rgb(rgb),
      .frame_start(frame_start)
   );

   // clock
   always #5 HCLK = ~HCLK;

   // pixel memory model: a single lit pixel at (5,3), or everything lit when forced
   assign pixel = pix_force | ((pixel_x == 10'd5) && (pixel_y == 9'd3));

   // Closed-form expectation after k enabled edges since the last restart
   function automatic logic [34:0] exp_at(int kk, bit force_px);
      int s, h0, v0, p, h1, v1;
      logic [9:0]  px;
      logic [8:0]  py;
      logic        hs_n, vs_n, von, fs;
      logic [11:0] c;
      s  = kk / CD;
      h0 = s % HT;
      v0 = (s / HT) % VT;
      px = 10'd0;
      py = 9'd0;
      if (h0 < HA && v0 < VA) begin
         px = 10'(h0);
         py = 9'(v0);
      end
      hs_n = 1'b1; vs_n = 1'b1; von = 1'b0; c = 12'h000; fs = 1'b0;
      if (kk >= CD) begin
         p    = s - 1;
         h1   = p % HT;
         v1   = (p / HT) % VT;
         hs_n = !(h1 >= HA + HF && h1 < HA + HF + HS);
         vs_n = !(v1 >= VA + VF && v1 < VA + VF + VS);
         von  = (h1 < HA) && (v1 < VA);
         if (von) begin
            if (force_px || (h1 == 5 && v1 == 3)) c = FG;
`ifdef VGA_BORDER_EN
            if (h1 == 0 || h1 == HA - 1 || v1 == 0 || v1 == VA - 1) c = FG;
`endif
         end
         fs = (kk % CD == 0) && (p % (HT * VT) == 0);
      end
      return {px, py, hs_n, vs_n, von, c, fs};
   endfunction

   // driver: one HCLK per call; accounts for the edge just taken, then applies new inputs
   task automatic cycle(input bit rst, input bit en);
      @(posedge HCLK);
      #1;
      if (!HRESET && enable) k = k + 1;
      else k = 0;
      HRESET = rst;
      enable = en;
      if (rst) k = 0;
      exp_q.push_back(exp_at(k, pix_force));
   endtask

   // monitor: scoreboard pop/compare plus sync pulse width checks
   int   hs_low = 0, vs_low = 0;
   logic hs_prev = 1'b1, vs_prev = 1'b1;
   always @(negedge HCLK) begin : mon
      logic [34:0] act, ex;
      act = {pixel_x, pixel_y, hsync_n, vsync_n, video_on, rgb, frame_start};
      if (exp_q.size() > 0) begin
         ex = exp_q.pop_front();
         tests_run++;
         if (act !== ex) begin
            failed++;
            $display("FAIL scoreboard t=%0t got x=%0d y=%0d hs_n=%b vs_n=%b von=%b rgb=%h fs=%b expected x=%0d y=%0d hs_n=%b vs_n=%b von=%b rgb=%h fs=%b",
                     $time, act[34:25], act[24:16], act[15], act[14], act[13], act[12:1], act[0],
                     ex[34:25], ex[24:16], ex[15], ex[14], ex[13], ex[12:1], ex[0]);
         end
      end
      if (hsync_n && !hs_prev && !HRESET && enable) begin
         tests_run++;
         if (hs_low != HS_LOW_CYC) begin
            failed++;
            $display("FAIL hsync_width got %0d cycles expected %0d", hs_low, HS_LOW_CYC);
         end
      end
      if (vsync_n && !vs_prev && !HRESET && enable) begin
         tests_run++;
         if (vs_low != VS_LOW_CYC) begin
            failed++;
            $display("FAIL vsync_width got %0d cycles expected %0d", vs_low, VS_LOW_CYC);
         end
      end
      if (HRESET || !enable) begin
         hs_low = 0;
         vs_low = 0;
      end else begin
         hs_low = hsync_n ? 0 : hs_low + 1;
         vs_low = vsync_n ? 0 : vs_low + 1;
      end
      hs_prev = hsync_n;
      vs_prev = vsync_n;
   end

   // stimulus sequence
   initial begin
      HRESET    = 1'b1;
      enable    = 1'b1;
      pix_force = 1'b0;
      k         = 0;
      // reset held, outputs at reset values
      repeat (5) cycle(1'b1, 1'b1);
      // release and free-run a bit over two frames
      repeat (1300) cycle(1'b0, 1'b1);
      // enable dropped mid-frame for 10 cycles, then resume from (0,0)
      repeat (10) cycle(1'b0, 1'b0);
      repeat (700) cycle(1'b0, 1'b1);
      // asynchronous reset mid-frame; memory returns 1 everywhere afterwards
      pix_force = 1'b1;
      repeat (3) cycle(1'b1, 1'b1);
      repeat (650) cycle(1'b0, 1'b1);
      // drain scoreboard with a bounded wait
      for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge HCLK);
      @(posedge HCLK);
      if (exp_q.size() > 0) begin
         failed++;
         $display("FAIL drain got %0d entries left expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
